// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master arbiter that sits upstream of the bus timing controller.
//   Master A (instruction fetch) and master B (load/store) each run a
//   four-phase request/ready handshake. One master is granted at a time, and
//   its transfer is forwarded on a single downstream four-phase port. Read
//   data is returned only to the granted master.
//
//   Ports
//     i_clock, i_reset         rising-edge clock, synchronous active-high reset
//     i_x_rw/request/address/wdata   master x (a or b) transfer inputs
//     o_x_ready, o_x_rdata     master x completion and registered read data
//     o_bus_rw/address/wdata   downstream transfer, muxed from the granted master
//     o_bus_request            downstream request (registered)
//     i_bus_ready, i_bus_rdata downstream completion and read data
//     o_grant_b                current/last grant, 0 = A, 1 = B
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   S_IDLE    | no transfer; waits for downstream release and an eligible master
//   S_ISSUE   | downstream request asserted on behalf of the granted master
//   S_RELEASE | granted master holds ready until it drops its request

module bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_a_rw,
   input  logic                  i_a_request,
   output logic                  o_a_ready,
   input  logic [ADDR_WIDTH-1:0] i_a_address,
   output logic [DATA_WIDTH-1:0] o_a_rdata,
   input  logic [DATA_WIDTH-1:0] i_a_wdata,
   input  logic                  i_b_rw,
   input  logic                  i_b_request,
   output logic                  o_b_ready,
   input  logic [ADDR_WIDTH-1:0] i_b_address,
   output logic [DATA_WIDTH-1:0] o_b_rdata,
   input  logic [DATA_WIDTH-1:0] i_b_wdata,
   output logic                  o_bus_rw,
   output logic                  o_bus_request,
   input  logic                  i_bus_ready,
   output logic [ADDR_WIDTH-1:0] o_bus_address,
   input  logic [DATA_WIDTH-1:0] i_bus_rdata,
   output logic [DATA_WIDTH-1:0] o_bus_wdata,
   output logic                  o_grant_b
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t                r_state,       w_state_next;
   logic                  r_grant_b,     w_grant_b_next;
   logic                  r_last_b,      w_last_b_next;
   logic                  r_bus_request, w_bus_request_next;
   logic                  r_a_ready,     w_a_ready_next;
   logic                  r_b_ready,     w_b_ready_next;
   logic [DATA_WIDTH-1:0] r_a_rdata,     w_a_rdata_next;
   logic [DATA_WIDTH-1:0] r_b_rdata,     w_b_rdata_next;

   logic w_a_elig;
   logic w_b_elig;
   logic w_pick_b;
   logic w_granted_request;

   // A master still holding ready from its previous transfer is not eligible,
   // so a finished master cannot be re-granted before it completes the handshake.
   assign w_a_elig = i_a_request & ~r_a_ready;
   assign w_b_elig = i_b_request & ~r_b_ready;

   // When both are eligible, round-robin hands the grant to whoever was not
   // served last; fixed priority always lets A win.
   assign w_pick_b = w_b_elig & (~w_a_elig | (~FIXED_PRIORITY & ~r_last_b));

   assign w_granted_request = r_grant_b ? i_b_request : i_a_request;

   always_comb begin
      w_state_next       = r_state;
      w_grant_b_next     = r_grant_b;
      w_last_b_next      = r_last_b;
      w_bus_request_next = r_bus_request;
      w_a_ready_next     = r_a_ready;
      w_b_ready_next     = r_b_ready;
      w_a_rdata_next     = r_a_rdata;
      w_b_rdata_next     = r_b_rdata;
      case (r_state)
         S_IDLE: begin
            w_bus_request_next = 1'b0;
            // A downstream still showing ready from the last transfer has not
            // released yet; starting now would look like an instant completion.
            if (!i_bus_ready && (w_a_elig || w_b_elig)) begin
               w_grant_b_next = w_pick_b;
               w_state_next   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (i_bus_ready) begin
               w_bus_request_next = 1'b0;
               if (r_grant_b) begin
                  w_b_rdata_next = i_bus_rdata;
                  w_b_ready_next = 1'b1;
               end else begin
                  w_a_rdata_next = i_bus_rdata;
                  w_a_ready_next = 1'b1;
               end
               w_state_next = S_RELEASE;
            end else begin
               w_bus_request_next = 1'b1;
            end
         end
         S_RELEASE: begin
            if (!w_granted_request) begin
               if (r_grant_b) begin
                  w_b_ready_next = 1'b0;
               end else begin
                  w_a_ready_next = 1'b0;
               end
               w_last_b_next = r_grant_b;
               w_state_next  = S_IDLE;
            end
         end
         default: begin
            w_state_next       = S_IDLE;
            w_bus_request_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_grant_b     <= 1'b0;
         r_last_b      <= 1'b1;
         r_bus_request <= 1'b0;
         r_a_ready     <= 1'b0;
         r_b_ready     <= 1'b0;
         r_a_rdata     <= '0;
         r_b_rdata     <= '0;
      end else begin
         r_state       <= w_state_next;
         r_grant_b     <= w_grant_b_next;
         r_last_b      <= w_last_b_next;
         r_bus_request <= w_bus_request_next;
         r_a_ready     <= w_a_ready_next;
         r_b_ready     <= w_b_ready_next;
         r_a_rdata     <= w_a_rdata_next;
         r_b_rdata     <= w_b_rdata_next;
      end
   end

   assign o_bus_rw      = r_grant_b ? i_b_rw      : i_a_rw;
   assign o_bus_address = r_grant_b ? i_b_address : i_a_address;
   assign o_bus_wdata   = r_grant_b ? i_b_wdata   : i_a_wdata;
   assign o_bus_request = r_bus_request;
   assign o_a_ready     = r_a_ready;
   assign o_b_ready     = r_b_ready;
   assign o_a_rdata     = r_a_rdata;
   assign o_b_rdata     = r_b_rdata;
   assign o_grant_b     = r_grant_b;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Bench for bus_arbiter. Instance dut drives a round-robin arbiter against
//   a behavioural downstream slave; instance dut_fp is a fixed-priority
//   arbiter with a simple inline slave.

module tb_bus_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          a_rw = 1'b0, a_req = 1'b0, a_rdy;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_rdata, a_wdata = '0;
   logic          b_rw = 1'b0, b_req = 1'b0, b_rdy;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_rdata, b_wdata = '0;
   logic          bus_rw, bus_req, bus_rdy, grant_b;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_rdata, bus_wdata;

   logic          f_a_rw = 1'b0, f_a_req = 1'b0, f_a_rdy;
   logic [AW-1:0] f_a_addr = '0;
   logic [DW-1:0] f_a_rdata, f_a_wdata = '0;
   logic          f_b_rw = 1'b0, f_b_req = 1'b0, f_b_rdy;
   logic [AW-1:0] f_b_addr = '0;
   logic [DW-1:0] f_b_rdata, f_b_wdata = '0;
   logic          f_bus_rw, f_bus_req, f_bus_rdy = 1'b0, f_grant_b;
   logic [AW-1:0] f_bus_addr;
   logic [DW-1:0] f_bus_rdata = '0, f_bus_wdata;

   int vectors     = 0;
   int miscompares = 0;

   bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b0)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_a_rw(a_rw), .i_a_request(a_req), .o_a_ready(a_rdy),
      .i_a_address(a_addr), .o_a_rdata(a_rdata), .i_a_wdata(a_wdata),
      .i_b_rw(b_rw), .i_b_request(b_req), .o_b_ready(b_rdy),
      .i_b_address(b_addr), .o_b_rdata(b_rdata), .i_b_wdata(b_wdata),
      .o_bus_rw(bus_rw), .o_bus_request(bus_req), .i_bus_ready(bus_rdy),
      .o_bus_address(bus_addr), .i_bus_rdata(bus_rdata), .o_bus_wdata(bus_wdata),
      .o_grant_b(grant_b)
   );

   bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b1)) dut_fp (
      .i_clock(clk), .i_reset(rst),
      .i_a_rw(f_a_rw), .i_a_request(f_a_req), .o_a_ready(f_a_rdy),
      .i_a_address(f_a_addr), .o_a_rdata(f_a_rdata), .i_a_wdata(f_a_wdata),
      .i_b_rw(f_b_rw), .i_b_request(f_b_req), .o_b_ready(f_b_rdy),
      .i_b_address(f_b_addr), .o_b_rdata(f_b_rdata), .i_b_wdata(f_b_wdata),
      .o_bus_rw(f_bus_rw), .o_bus_request(f_bus_req), .i_bus_ready(f_bus_rdy),
      .o_bus_address(f_bus_addr), .i_bus_rdata(f_bus_rdata), .o_bus_wdata(f_bus_wdata),
      .o_grant_b(f_grant_b)
   );

   // Downstream slave for dut: answers after a delay, holds ready after the
   // request drops for a configurable number of extra cycles. Acts 2 time
   // units after each rising edge, so at edge+1 the bench sees the ready value
   // that the DUT sampled at that edge.
   logic          slv_en    = 1'b0;
   bit            slv_rand  = 1'b0;
   int            slv_delay = 1;
   int            slv_hold  = 0;
   logic [DW-1:0] slv_fixed = '0;
   logic [DW-1:0] slv_data  = '0;

   initial begin : slave
      int phase;
      int cnt;
      int h;
      phase = 0; cnt = 0; h = 0;
      bus_rdy = 1'b0; bus_rdata = '0;
      forever begin
         @(posedge clk); #2;
         if (!slv_en) begin
            bus_rdy = 1'b0; phase = 0;
         end else begin
            case (phase)
               0: begin
                  if (bus_req) begin
                     cnt = slv_rand ? int'($urandom_range(0, 3)) : slv_delay;
                     phase = 1;
                  end
               end
               1: begin
                  if (cnt == 0) begin
                     slv_data  = slv_rand ? $urandom : slv_fixed;
                     bus_rdata = slv_data;
                     bus_rdy   = 1'b1;
                     phase     = 2;
                  end else cnt--;
               end
               2: begin
                  if (!bus_req) begin
                     h = slv_rand ? int'($urandom_range(0, 2)) : slv_hold;
                     if (h == 0) begin
                        bus_rdy = 1'b0; phase = 0;
                     end else begin
                        cnt = h - 1; phase = 3;
                     end
                  end
               end
               default: begin
                  if (cnt == 0) begin
                     bus_rdy = 1'b0; phase = 0;
                  end else cnt--;
               end
            endcase
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; slv_en = 1'b0; slv_rand = 1'b0; slv_delay = 1; slv_hold = 0;
      a_req = 1'b0; a_rw = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_rw = 1'b0; b_addr = '0; b_wdata = '0;
      f_a_req = 1'b0; f_b_req = 1'b0; f_bus_rdy = 1'b0; f_bus_rdata = '0;
      tick; tick;
      rst = 1'b0; slv_en = 1'b1;
   endtask

   // Scenario: A reads 0x100, slave answers 0xDEADBEEF a few cycles later.
   task automatic test_single_read;
      bit b_seen;
      bit got;
      do_reset;
      slv_delay = 2; slv_fixed = 32'hDEAD_BEEF;
      a_rw = 1'b0; a_addr = 32'h100; a_req = 1'b1;
      tick;
      vectors++;
      if (bus_req !== 1'b0) begin
         miscompares++; $display("FAIL read_issue_latency: bus_req=%b expected 0", bus_req);
      end
      tick;
      vectors++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_rw !== 1'b0 || grant_b !== 1'b0) begin
         miscompares++;
         $display("FAIL read_bus_out: req=%b addr=%h rw=%b grant_b=%b expected 1/100/0/0",
                  bus_req, bus_addr, bus_rw, grant_b);
      end
      b_seen = 1'b0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick;
         if (b_rdy) b_seen = 1'b1;
         if (a_rdy) got = 1'b1;
      end
      vectors++;
      if (!got || a_rdata !== 32'hDEAD_BEEF || bus_req !== 1'b0 || b_seen) begin
         miscompares++;
         $display("FAIL read_complete: a_rdy=%b a_rdata=%h bus_req=%b b_seen=%b expected 1/deadbeef/0/0",
                  got, a_rdata, bus_req, b_seen);
      end
      a_req = 1'b0;
      tick;
      vectors++;
      if (a_rdy !== 1'b0) begin
         miscompares++; $display("FAIL read_release: a_rdy=%b expected 0", a_rdy);
      end
      tick;
   endtask

   // Reset with both masters requesting: nothing may start, outputs clear.
   task automatic test_reset;
      a_req = 1'b1; b_req = 1'b1; f_a_req = 1'b1; f_b_req = 1'b1;
      rst = 1'b1;
      tick; tick;
      vectors++;
      if (bus_req !== 1'b0 || a_rdy !== 1'b0 || b_rdy !== 1'b0 || grant_b !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: req=%b a_rdy=%b b_rdy=%b grant_b=%b expected all 0",
                  bus_req, a_rdy, b_rdy, grant_b);
      end
      vectors++;
      if (a_rdata !== '0 || b_rdata !== '0) begin
         miscompares++; $display("FAIL reset_rdata: a=%h b=%h expected 0", a_rdata, b_rdata);
      end
      vectors++;
      if (f_bus_req !== 1'b0 || f_a_rdy !== 1'b0 || f_b_rdy !== 1'b0 || f_grant_b !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_fp: req=%b a_rdy=%b b_rdy=%b grant_b=%b expected all 0",
                  f_bus_req, f_a_rdy, f_b_rdy, f_grant_b);
      end
      a_req = 1'b0; b_req = 1'b0; f_a_req = 1'b0; f_b_req = 1'b0;
      rst = 1'b0;
      tick; tick;
      vectors++;
      if (bus_req !== 1'b0) begin
         miscompares++; $display("FAIL reset_idle: bus_req=%b expected 0", bus_req);
      end
   endtask

   // Both masters request together from reset, twice: order must be A,B,A,B.
   task automatic test_round_robin;
      int order[4];
      int n;
      int served;
      do_reset;
      slv_rand = 1'b1;
      n = 0;
      for (int r = 0; r < 2; r++) begin
         a_addr = 32'h1000 + r; b_addr = 32'h2000 + r;
         a_req = 1'b1; b_req = 1'b1;
         served = 0;
         for (int i = 0; i < 80 && served < 2; i++) begin
            tick;
            if (a_rdy && a_req) begin order[n] = 0; n++; served++; a_req = 1'b0; end
            if (b_rdy && b_req) begin order[n] = 1; n++; served++; b_req = 1'b0; end
         end
         vectors++;
         if (served != 2) begin
            miscompares++; $display("FAIL rr_timeout: served %0d of 2 in round %0d", served, r);
            a_req = 1'b0; b_req = 1'b0;
         end
         for (int i = 0; i < 10 && (a_rdy || b_rdy); i++) tick;
         tick; tick; tick;
      end
      for (int k = 0; k < n; k++) begin
         vectors++;
         if (order[k] != (k % 2)) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: got master %0d expected %0d", k, order[k], k % 2);
         end
      end
   endtask

   // Fixed priority: A re-requests at once, B held; B must starve, then win.
   task automatic test_fixed_priority;
      int a_cnt;
      int b_cnt;
      bit b_got;
      do_reset;
      a_cnt = 0; b_cnt = 0;
      f_a_addr = 32'hA0; f_b_addr = 32'hB0;
      f_a_req = 1'b1; f_b_req = 1'b1;
      for (int i = 0; i < 300 && a_cnt < 10; i++) begin
         tick;
         f_bus_rdy = f_bus_req; f_bus_rdata = $urandom;
         if (f_b_rdy) b_cnt++;
         if (f_a_rdy && f_a_req) begin
            a_cnt++; f_a_req = 1'b0;
         end else if (!f_a_req && !f_a_rdy) begin
            f_a_req = 1'b1;
         end
      end
      vectors++;
      if (a_cnt != 10 || b_cnt != 0) begin
         miscompares++;
         $display("FAIL fp_starve: a_transfers=%0d b_readies=%0d expected 10/0", a_cnt, b_cnt);
      end
      b_got = 1'b0;
      for (int i = 0; i < 40 && !b_got; i++) begin
         tick;
         f_bus_rdy = f_bus_req;
         if (f_b_rdy) b_got = 1'b1;
      end
      vectors++;
      if (!b_got || f_grant_b !== 1'b1) begin
         miscompares++; $display("FAIL fp_b_after_a: b_rdy=%b grant_b=%b expected 1/1", b_got, f_grant_b);
      end
      f_b_req = 1'b0;
      tick; f_bus_rdy = 1'b0; tick; tick;
   endtask

   // B write raised during A's ISSUE must wait and then go out intact.
   task automatic test_wait_pending;
      bit seen;
      bit a_done;
      bit a_released;
      do_reset;
      slv_delay = 3; slv_fixed = 32'h1234_5678;
      a_rw = 1'b0; a_addr = 32'h300; a_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick;
         if (bus_req) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++; $display("FAIL wp_a_issue: bus_req never rose");
      end
      b_rw = 1'b1; b_addr = 32'h200; b_wdata = 32'h55AA_55AA; b_req = 1'b1;
      a_done = 1'b0; a_released = 1'b0;
      for (int i = 0; i < 30 && !a_released; i++) begin
         tick;
         if (a_done && !a_rdy) a_released = 1'b1;
         if (a_rdy && a_req) begin a_done = 1'b1; a_req = 1'b0; end
         if (!a_released) begin
            vectors++;
            if (grant_b !== 1'b0 || bus_addr !== 32'h300 || bus_rw !== 1'b0 || b_rdy !== 1'b0) begin
               miscompares++;
               $display("FAIL wp_hold_a: grant_b=%b addr=%h rw=%b b_rdy=%b expected 0/300/0/0",
                        grant_b, bus_addr, bus_rw, b_rdy);
            end
         end
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (bus_req) seen = 1'b1; else tick;
      end
      vectors++;
      if (!seen || grant_b !== 1'b1 || bus_rw !== 1'b1 || bus_addr !== 32'h200 ||
          bus_wdata !== 32'h55AA_55AA) begin
         miscompares++;
         $display("FAIL wp_b_issue: req=%b grant_b=%b rw=%b addr=%h wdata=%h expected 1/1/1/200/55aa55aa",
                  bus_req, grant_b, bus_rw, bus_addr, bus_wdata);
      end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick;
         if (b_rdy) seen = 1'b1;
      end
      vectors++;
      if (!seen || b_rdata !== 32'h1234_5678) begin
         miscompares++; $display("FAIL wp_b_done: b_rdy=%b b_rdata=%h expected 1/12345678", seen, b_rdata);
      end
      b_req = 1'b0;
      tick; tick;
   endtask

   // Reset pulsed during ISSUE abandons the transfer; next request works.
   task automatic test_reset_in_issue;
      bit seen;
      do_reset;
      slv_en = 1'b0;
      a_rw = 1'b0; a_addr = 32'h40; a_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick;
         if (bus_req) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++; $display("FAIL rii_issue: bus_req never rose");
      end
      rst = 1'b1; a_req = 1'b0;
      tick;
      vectors++;
      if (bus_req !== 1'b0 || a_rdy !== 1'b0 || b_rdy !== 1'b0 || grant_b !== 1'b0) begin
         miscompares++;
         $display("FAIL rii_after_reset: req=%b a_rdy=%b b_rdy=%b grant_b=%b expected all 0",
                  bus_req, a_rdy, b_rdy, grant_b);
      end
      rst = 1'b0;
      tick; tick;
      vectors++;
      if (bus_req !== 1'b0 || a_rdy !== 1'b0) begin
         miscompares++; $display("FAIL rii_idle: req=%b a_rdy=%b expected 0/0", bus_req, a_rdy);
      end
      slv_en = 1'b1; slv_delay = 0; slv_fixed = 32'hCAFE_F00D;
      a_addr = 32'h44; a_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick;
         if (a_rdy) seen = 1'b1;
      end
      vectors++;
      if (!seen || a_rdata !== 32'hCAFE_F00D) begin
         miscompares++; $display("FAIL rii_new_read: a_rdy=%b a_rdata=%h expected 1/cafef00d", seen, a_rdata);
      end
      a_req = 1'b0;
      tick; tick;
   endtask

   // Slave holds ready 3 extra cycles; pending B must wait for it to fall.
   task automatic test_ready_hold;
      bit seen;
      bit low;
      bit rose;
      do_reset;
      slv_delay = 1; slv_hold = 3; slv_fixed = 32'h0BAD_CAFE;
      a_addr = 32'h500; b_addr = 32'h600; a_req = 1'b1; b_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick;
         if (a_rdy) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++; $display("FAIL rh_a_done: a_rdy never rose");
      end
      a_req = 1'b0;
      low = 1'b0; rose = 1'b0;
      for (int i = 0; i < 20 && !rose; i++) begin
         tick;
         vectors++;
         if (!low) begin
            if (bus_req !== 1'b0) begin
               miscompares++; $display("FAIL rh_held: bus_req=%b while ready high, expected 0", bus_req);
            end
            if (bus_rdy == 1'b0) low = 1'b1;
         end else begin
            rose = 1'b1;
            if (bus_req !== 1'b1 || grant_b !== 1'b1) begin
               miscompares++;
               $display("FAIL rh_b_start: req=%b grant_b=%b one cycle after ready fell, expected 1/1",
                        bus_req, grant_b);
            end
         end
      end
      slv_hold = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick;
         if (b_rdy) seen = 1'b1;
      end
      vectors++;
      if (!seen || b_rdata !== 32'h0BAD_CAFE) begin
         miscompares++; $display("FAIL rh_b_done: b_rdy=%b b_rdata=%h expected 1/0badcafe", seen, b_rdata);
      end
      b_req = 1'b0;
      tick; tick;
   endtask

   // Random traffic against a transaction-level model: which master should
   // win each arbitration, what the bus carries, and what data comes back.
   task automatic test_random;
      bit            pend[2];
      bit            m_rw[2];
      logic [AW-1:0] m_addr[2];
      logic [DW-1:0] m_wd[2];
      bit            e1[2];
      bit            e2[2];
      bit            prev_rdy[2];
      bit            prev_req;
      bit            allow;
      logic          rdy_v;
      logic [DW-1:0] rd_v;
      int            last;
      int            cur;
      int            expw;
      do_reset;
      slv_rand = 1'b1;
      for (int m = 0; m < 2; m++) begin
         pend[m] = 1'b0; e1[m] = 1'b0; e2[m] = 1'b0; prev_rdy[m] = 1'b0;
         m_rw[m] = 1'b0; m_addr[m] = '0; m_wd[m] = '0;
      end
      prev_req = 1'b0; last = 1; cur = -1;
      for (int cyc = 0; cyc < 3300; cyc++) begin
         allow = (cyc < 3000);
         if (!allow && !pend[0] && !pend[1]) break;
         tick;
         if (bus_req && !prev_req) begin
            // The decision edge is the one before the edge that raised the request.
            if (e2[0] && e2[1]) expw = (last == 0) ? 1 : 0;
            else if (e2[0]) expw = 0;
            else if (e2[1]) expw = 1;
            else expw = -1;
            vectors++;
            if (expw < 0) begin
               miscompares++; $display("FAIL rand_grant: bus request rose with no eligible master");
            end else if (grant_b !== (expw == 1) || bus_rw !== m_rw[expw] ||
                         bus_addr !== m_addr[expw] || bus_wdata !== m_wd[expw]) begin
               miscompares++;
               $display("FAIL rand_grant: grant_b=%b rw=%b addr=%h wdata=%h expected %0d/%b/%h/%h",
                        grant_b, bus_rw, bus_addr, bus_wdata, expw, m_rw[expw], m_addr[expw], m_wd[expw]);
            end
            cur = expw;
         end
         prev_req = bus_req;
         for (int m = 0; m < 2; m++) begin
            rdy_v = (m == 0) ? a_rdy : b_rdy;
            rd_v  = (m == 0) ? a_rdata : b_rdata;
            if (rdy_v && !prev_rdy[m]) begin
               vectors++;
               if (!pend[m] || m != cur || rd_v !== slv_data) begin
                  miscompares++;
                  $display("FAIL rand_ready: master %0d pend=%b cur=%0d rdata=%h expected data %h",
                           m, pend[m], cur, rd_v, slv_data);
               end
               if (pend[m]) begin pend[m] = 1'b0; last = m; end
               cur = -1;
            end
            prev_rdy[m] = rdy_v;
            if (allow && !pend[m] && !rdy_v && $urandom_range(0, 2) == 0) begin
               pend[m] = 1'b1; m_rw[m] = $urandom_range(0, 1) == 1;
               m_addr[m] = $urandom; m_wd[m] = $urandom;
            end
            e2[m] = e1[m];
            e1[m] = pend[m] && !rdy_v;
         end
         a_req = pend[0]; a_rw = m_rw[0]; a_addr = m_addr[0]; a_wdata = m_wd[0];
         b_req = pend[1]; b_rw = m_rw[1]; b_addr = m_addr[1]; b_wdata = m_wd[1];
      end
      vectors++;
      if (pend[0] || pend[1]) begin
         miscompares++; $display("FAIL rand_drain: pending a=%b b=%b expected none", pend[0], pend[1]);
      end
   endtask

   initial begin
      test_single_read;
      test_reset;
      test_round_robin;
      test_fixed_priority;
      test_wait_pending;
      test_reset_in_issue;
      test_ready_hold;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
